// File: rtl/mac_job_sequencer_if.sv
// Handshake bundle between the job source, the posit MAC and the result consumer.
// The sequencer uses the slave modport; the driving side uses master.
interface mac_job_sequencer_if #(
   parameter int WIDTH = 8,
   parameter int K     = 9,
   parameter int NW    = 16
);
   localparam int AW = (K > 1) ? $clog2(K) : 1;

   logic             start_i;
   logic [NW-1:0]    n_dot_i;
   logic             busy_o;
   logic             done_o;
   logic             w_we_i;
   logic [AW-1:0]    w_addr_i;
   logic [WIDTH-1:0] w_data_i;
   logic             din_vld_i;
   logic [WIDTH-1:0] din_i;
   logic             din_rdy_o;
   logic             mac_vld_o;
   logic [WIDTH-1:0] mac_win_o;
   logic [WIDTH-1:0] mac_din_o;
   logic             mac_vld_acc_i;
   logic [WIDTH-1:0] mac_acc_i;
   logic             res_vld_o;
   logic [WIDTH-1:0] res_data_o;
   logic             res_rdy_i;
   logic             err_o;

   modport master (
      output start_i, n_dot_i, w_we_i, w_addr_i, w_data_i, din_vld_i, din_i,
             mac_vld_acc_i, mac_acc_i, res_rdy_i,
      input  busy_o, done_o, din_rdy_o, mac_vld_o, mac_win_o, mac_din_o,
             res_vld_o, res_data_o, err_o
   );

   modport slave (
      input  start_i, n_dot_i, w_we_i, w_addr_i, w_data_i, din_vld_i, din_i,
             mac_vld_acc_i, mac_acc_i, res_rdy_i,
      output busy_o, done_o, din_rdy_o, mac_vld_o, mac_win_o, mac_din_o,
             res_vld_o, res_data_o, err_o
   );
endinterface

// File: rtl/mac_job_sequencer.sv
// Streams weight/activation pairs into the posit MAC in K-beat dot products and
// collects results into a FIFO; credits keep the FIFO from ever overflowing.
module mac_job_sequencer #(
   parameter int WIDTH     = 8,
   parameter int K         = 9,
   parameter int RES_DEPTH = 4,
   parameter int NW        = 16
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   mac_job_sequencer_if.slave   bus
);
   localparam int AW = (K > 1) ? $clog2(K) : 1;
   localparam int PW = $clog2(RES_DEPTH);
   localparam int CW = PW + 1;

   typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DRAIN = 2'd2} state_t;
   state_t state, state_nxt;

   logic [AW-1:0]    beat_idx;
   logic [NW-1:0]    dot_cnt, n_dot;
   logic [CW-1:0]    outstanding, fifo_count;
   logic [PW-1:0]    wr_ptr, rd_ptr;
   logic [WIDTH-1:0] weight   [K];
   logic [WIDTH-1:0] fifo_mem [RES_DEPTH];
   logic [WIDTH-1:0] mac_win, mac_din;
   logic             zero_done, err, mac_vld;
   logic             busy, done, din_rdy;
   logic             hs, last_beat, last_dot, credit_ok, start_job, start_empty;
   logic             fifo_full, res_vld, pop, push, acc_ok, outst_inc;
   logic [CW:0]      committed;

   // A dot may only start if its result is guaranteed a FIFO slot.
   assign committed   = {1'b0, fifo_count} + {1'b0, outstanding};
   assign credit_ok   = committed < (CW+1)'(RES_DEPTH);
   assign last_beat   = (beat_idx == AW'(K - 1));
   assign last_dot    = (dot_cnt == n_dot - NW'(1));
   assign start_job   = (state == IDLE) && bus.start_i && (bus.n_dot_i != '0);
   assign start_empty = (state == IDLE) && bus.start_i && (bus.n_dot_i == '0);
   assign hs          = bus.din_vld_i && din_rdy;
   assign outst_inc   = hs && (beat_idx == '0);
   assign acc_ok      = bus.mac_vld_acc_i && (outstanding != '0);
   assign fifo_full   = (fifo_count == CW'(RES_DEPTH));
   assign res_vld     = (fifo_count != '0);
   assign pop         = res_vld && bus.res_rdy_i;
   assign push        = acc_ok && !fifo_full;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) state <= IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (start_job) state_nxt = RUN;
         RUN:     if (hs && last_beat && last_dot) state_nxt = DRAIN;
         DRAIN:   if (outstanding == '0) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      busy    = (state != IDLE);
      done    = ((state == DRAIN) && (outstanding == '0)) || zero_done;
      din_rdy = (state == RUN) && ((beat_idx != '0) || credit_ok);
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         beat_idx    <= '0;
         dot_cnt     <= '0;
         n_dot       <= '0;
         outstanding <= '0;
         fifo_count  <= '0;
         wr_ptr      <= '0;
         rd_ptr      <= '0;
         zero_done   <= 1'b0;
         err         <= 1'b0;
         mac_vld     <= 1'b0;
         mac_win     <= '0;
         mac_din     <= '0;
         for (int i = 0; i < K; i++) weight[i] <= '0;
      end else begin
         zero_done <= start_empty;
         mac_vld   <= hs;
         if (start_job) begin
            n_dot    <= bus.n_dot_i;
            dot_cnt  <= '0;
            beat_idx <= '0;
         end
         if (hs) begin
            mac_din <= bus.din_i;
            mac_win <= weight[beat_idx];
            if (last_beat) begin
               beat_idx <= '0;
               dot_cnt  <= dot_cnt + NW'(1);
            end else begin
               beat_idx <= beat_idx + AW'(1);
            end
         end
         case ({outst_inc, acc_ok})
            2'b10:   outstanding <= outstanding + CW'(1);
            2'b01:   outstanding <= outstanding - CW'(1);
            default: ;
         endcase
         // Unsolicited results and pushes into a full FIFO are both MAC faults.
         if (bus.mac_vld_acc_i && ((outstanding == '0) || fifo_full)) err <= 1'b1;
         if (push) wr_ptr <= wr_ptr + PW'(1);
         if (pop)  rd_ptr <= rd_ptr + PW'(1);
         case ({push, pop})
            2'b10:   fifo_count <= fifo_count + CW'(1);
            2'b01:   fifo_count <= fifo_count - CW'(1);
            default: ;
         endcase
         if (bus.w_we_i && !busy && (32'(bus.w_addr_i) < K))
            weight[bus.w_addr_i] <= bus.w_data_i;
      end
   end

   always_ff @(posedge clk_i) begin
      if (push) fifo_mem[wr_ptr] <= bus.mac_acc_i;
   end

   assign bus.busy_o     = busy;
   assign bus.done_o     = done;
   assign bus.din_rdy_o  = din_rdy;
   assign bus.mac_vld_o  = mac_vld;
   assign bus.mac_win_o  = mac_win;
   assign bus.mac_din_o  = mac_din;
   assign bus.res_vld_o  = res_vld;
   assign bus.res_data_o = res_vld ? fifo_mem[rd_ptr] : '0;
   assign bus.err_o      = err;
endmodule

// File: tb/tb_mac_job_sequencer.sv
// Scoreboard bench for mac_job_sequencer with a behavioural stand-in for the posit MAC
// (returns posit<8,2> 9.0 = 0x59 for nine 1.0*1.0 beats, a checksum of the beats otherwise).
module tb_mac_job_sequencer;
   localparam int WIDTH = 8, K = 9, RES_DEPTH = 4, NW = 16, LAT = 3;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   mac_job_sequencer_if #(.WIDTH(WIDTH), .K(K), .NW(NW)) bus ();
   mac_job_sequencer #(.WIDTH(WIDTH), .K(K), .RES_DEPTH(RES_DEPTH), .NW(NW)) dut (
      .clk_i (clk),
      .rst_i (rst),
      .bus   (bus)
   );

   int n_chk = 0, n_fail = 0;
   logic [7:0] tb_w [K];
   logic [7:0] act_q [$];
   logic [7:0] exp_q [$];
   logic [7:0] pend_val [$];
   int         pend_due [$];
   int cyc = 0, n_beats = 0, n_hs = 0, n_res = 0, n_done = 0;
   int exp_beat = 0, mdl_beat = 0;
   logic [7:0] exp_sum = 8'h00, mdl_sum = 8'h00;
   bit exp_one = 1'b1, mdl_one = 1'b1;
   bit mac_en = 1'b1, rdy_on = 1'b1;
   int gap = 0, act_fix = -1;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [7:0] dot_step(input logic [7:0] s, input logic [7:0] w, input logic [7:0] d);
      return (s * 8'd3) + (w ^ d);
   endfunction

   function automatic logic [7:0] dot_result(input logic [7:0] s, input bit one);
      return one ? 8'h59 : s;
   endfunction

   task automatic model_reset();
      act_q.delete(); exp_q.delete(); pend_val.delete(); pend_due.delete();
      exp_beat = 0; mdl_beat = 0; exp_sum = 8'h00; mdl_sum = 8'h00;
      exp_one = 1'b1; mdl_one = 1'b1;
   endtask

   task automatic cycle();
      logic hs_pre, pop_pre;
      logic [7:0] din_pre, pop_data, w, d;
      #1;
      hs_pre   = bus.din_vld_i && bus.din_rdy_o;
      din_pre  = bus.din_i;
      pop_pre  = bus.res_vld_o && bus.res_rdy_i;
      pop_data = bus.res_data_o;
      if (hs_pre) begin
         n_hs++;
         act_q.push_back(din_pre);
         exp_one  = exp_one && (tb_w[exp_beat] == 8'h40) && (din_pre == 8'h40);
         exp_sum  = dot_step(exp_sum, tb_w[exp_beat], din_pre);
         exp_beat++;
         if (exp_beat == K) begin
            exp_q.push_back(dot_result(exp_sum, exp_one));
            exp_beat = 0; exp_sum = 8'h00; exp_one = 1'b1;
         end
      end
      @(posedge clk);
      #1;
      cyc++;
      if (pop_pre) begin
         n_res++;
         check("res_expected", exp_q.size() > 0, 1);
         if (exp_q.size() > 0) check("res_data", pop_data, exp_q.pop_front());
      end
      if (bus.mac_vld_o) begin
         n_beats++;
         w = bus.mac_win_o;
         d = bus.mac_din_o;
         check("mac_win", w, tb_w[mdl_beat]);
         check("mac_beat_expected", act_q.size() > 0, 1);
         if (act_q.size() > 0) check("mac_din", d, act_q.pop_front());
         mdl_one = mdl_one && (w == 8'h40) && (d == 8'h40);
         mdl_sum = dot_step(mdl_sum, w, d);
         mdl_beat++;
         if (mdl_beat == K) begin
            pend_val.push_back(dot_result(mdl_sum, mdl_one));
            pend_due.push_back(cyc + LAT);
            mdl_beat = 0; mdl_sum = 8'h00; mdl_one = 1'b1;
         end
      end
      if (bus.done_o) n_done++;
      if (mac_en) begin
         if (pend_due.size() > 0 && pend_due[0] <= cyc) begin
            bus.mac_vld_acc_i = 1'b1;
            bus.mac_acc_i     = pend_val.pop_front();
            void'(pend_due.pop_front());
         end else begin
            bus.mac_vld_acc_i = 1'b0;
         end
      end
   endtask

   task automatic step();
      bus.din_vld_i = ($urandom_range(99) >= gap);
      bus.din_i     = (act_fix >= 0) ? 8'(act_fix) : 8'($urandom);
      bus.res_rdy_i = rdy_on;
      cycle();
   endtask

   task automatic w_write(input int addr, input logic [7:0] data);
      bus.w_we_i   = 1'b1;
      bus.w_addr_i = 4'(addr);
      bus.w_data_i = data;
      cycle();
      bus.w_we_i   = 1'b0;
   endtask

   task automatic start_job(input int n);
      bus.n_dot_i   = 16'(n);
      bus.start_i   = 1'b1;
      bus.din_vld_i = 1'b0;
      cycle();
      bus.start_i   = 1'b0;
   endtask

   task automatic wait_done(input int d0, input int budget);
      for (int i = 0; i < budget && n_done == d0; i++) step();
      check("job_done", n_done - d0, 1);
      bus.din_vld_i = 1'b0;
   endtask

   task automatic flush();
      bus.res_rdy_i = 1'b1;
      for (int i = 0; i < 60 && (exp_q.size() > 0 || pend_due.size() > 0); i++) cycle();
      check("results_drained", exp_q.size(), 0);
   endtask

   task automatic run_job(input int n, input int budget);
      int d0;
      d0 = n_done;
      start_job(n);
      wait_done(d0, budget);
      flush();
   endtask

   initial begin
      int b0, r0, h0, d0;
      bus.start_i = 1'b0; bus.n_dot_i = '0; bus.w_we_i = 1'b0; bus.w_addr_i = '0;
      bus.w_data_i = '0; bus.din_vld_i = 1'b0; bus.din_i = '0; bus.mac_vld_acc_i = 1'b0;
      bus.mac_acc_i = '0; bus.res_rdy_i = 1'b0;
      for (int i = 0; i < K; i++) tb_w[i] = 8'h00;
      model_reset();
      repeat (3) cycle();
      rst = 1'b0;
      cycle();
      check("rst_busy", bus.busy_o, 0);
      check("rst_done", bus.done_o, 0);
      check("rst_din_rdy", bus.din_rdy_o, 0);
      check("rst_mac_vld", bus.mac_vld_o, 0);
      check("rst_mac_win", bus.mac_win_o, 0);
      check("rst_res_vld", bus.res_vld_o, 0);
      check("rst_err", bus.err_o, 0);

      // 1: unit weights and activations give posit 9.0
      for (int i = 0; i < K; i++) begin tb_w[i] = 8'h40; w_write(i, 8'h40); end
      act_fix = 8'h40; gap = 0; rdy_on = 1'b1;
      b0 = n_beats; r0 = n_res;
      run_job(1, 100);
      check("t1_beats", n_beats - b0, 9);
      check("t1_results", n_res - r0, 1);
      check("t1_idle", bus.busy_o, 0);

      // 2: credit limit with a stalled consumer
      for (int i = 0; i < K; i++) begin tb_w[i] = 8'(8'h11 * (i + 1)); w_write(i, tb_w[i]); end
      act_fix = -1; rdy_on = 1'b0;
      h0 = n_hs; r0 = n_res; d0 = n_done;
      start_job(8);
      repeat (60) step();
      check("t2_issued_beats", n_hs - h0, 36);
      check("t2_din_rdy_low", bus.din_rdy_o, 0);
      check("t2_res_vld", bus.res_vld_o, 1);
      check("t2_busy", bus.busy_o, 1);
      rdy_on = 1'b1;
      wait_done(d0, 400);
      flush();
      check("t2_results", n_res - r0, 8);
      check("t2_total_beats", n_hs - h0, 72);

      // 3: random gaps between beats
      gap = 50; b0 = n_beats; r0 = n_res;
      run_job(3, 400);
      check("t3_beats", n_beats - b0, 27);
      check("t3_results", n_res - r0, 3);
      gap = 0;

      // 4: empty job, then weight write attempted while busy
      bus.n_dot_i = '0; bus.start_i = 1'b1;
      cycle();
      bus.start_i = 1'b0;
      check("t4_done_pulse", bus.done_o, 1);
      check("t4_busy_never", bus.busy_o, 0);
      cycle();
      check("t4_done_clear", bus.done_o, 0);
      check("t4_still_idle", bus.busy_o, 0);
      d0 = n_done;
      start_job(1);
      check("t4_busy_set", bus.busy_o, 1);
      bus.w_we_i = 1'b1; bus.w_addr_i = 4'd0; bus.w_data_i = 8'hEE;
      step();
      bus.w_we_i = 1'b0;
      wait_done(d0, 100);
      flush();
      b0 = n_beats;
      run_job(1, 100);
      check("t4_beats_after", n_beats - b0, 9);
      check("t4_no_err", bus.err_o, 0);

      // 5: unsolicited MAC result
      mac_en = 1'b0;
      bus.mac_vld_acc_i = 1'b1; bus.mac_acc_i = 8'h77;
      cycle();
      bus.mac_vld_acc_i = 1'b0;
      check("t5_err_set", bus.err_o, 1);
      check("t5_no_push", bus.res_vld_o, 0);
      repeat (5) cycle();
      check("t5_err_sticky", bus.err_o, 1);
      mac_en = 1'b1;

      // 6: reset in the middle of dot 2
      for (int i = 0; i < K; i++) begin tb_w[i] = 8'(8'h21 + 7 * i); w_write(i, tb_w[i]); end
      h0 = n_hs;
      start_job(3);
      for (int i = 0; i < 100 && (n_hs - h0) < 13; i++) step();
      check("t6_reached_beat4", n_hs - h0, 13);
      rst = 1'b1;
      bus.din_vld_i = 1'b0; bus.mac_vld_acc_i = 1'b0;
      mac_en = 1'b0;
      cycle();
      check("t6_busy", bus.busy_o, 0);
      check("t6_done", bus.done_o, 0);
      check("t6_din_rdy", bus.din_rdy_o, 0);
      check("t6_mac_vld", bus.mac_vld_o, 0);
      check("t6_mac_win", bus.mac_win_o, 0);
      check("t6_mac_din", bus.mac_din_o, 0);
      check("t6_res_vld", bus.res_vld_o, 0);
      check("t6_res_data", bus.res_data_o, 0);
      check("t6_err", bus.err_o, 0);
      rst = 1'b0;
      model_reset();
      mac_en = 1'b1;
      for (int i = 0; i < K; i++) tb_w[i] = 8'h00;
      b0 = n_beats; r0 = n_res;
      run_job(1, 100);
      check("t6_new_beats", n_beats - b0, 9);
      check("t6_new_results", n_res - r0, 1);
      check("t6_new_err", bus.err_o, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
